// File: rtl/jtframe_mailbox.sv
// Bidirectional host/sub mailbox. Each direction is either a FIFO or a legacy single latch.
// All strobes are qualified by cen and can optionally fire on their rising edge only.
module jtframe_mailbox_q #(
  parameter int DW   = 8,
  parameter int AW   = 2,
  parameter int MODE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          pend,
  output logic          full,
  output logic          ovf,
  output logic          unf
);

  if (MODE != 0) begin : g_fifo
    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, rptr_inc;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic          empty, do_push, do_pop;

    always_comb begin
      empty    = (cnt_q == '0);
      do_pop   = pop & ~empty;
      // A pop frees a slot in the same cycle, so a push into a full queue still lands.
      do_push  = push & (~cnt_q[AW] | do_pop);
      rptr_inc = rptr_q + PTR_ONE;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (clr) begin
        wptr_d = '0;
        rptr_d = '0;
        cnt_d  = '0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
      end else begin
        if (do_push) wptr_d = wptr_q + PTR_ONE;
        if (do_pop)  rptr_d = rptr_inc;
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (push && !do_push) ovf_d = 1'b1;
        if (pop && empty)     unf_d = 1'b1;
        // New head comes from memory, or bypasses din when the queue is empty after the pop.
        if (do_pop && cnt_q > (AW+1)'(1))
          dout_d = mem_q[rptr_inc];
        else if (do_push && cnt_q == (AW+1)'(do_pop))
          dout_d = din;
      end
    end

    always_ff @(posedge clk) begin
      if (do_push && !clr) mem_q[wptr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
        dout_q <= '0;
        ovf_q  <= 1'b0;
        unf_q  <= 1'b0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
        dout_q <= dout_d;
        ovf_q  <= ovf_d;
        unf_q  <= unf_d;
      end
    end

    assign dout = dout_q;
    assign pend = ~empty;
    assign full = cnt_q[AW];
    assign ovf  = ovf_q;
    assign unf  = unf_q;
  end else begin : g_latch
    logic [DW-1:0] dout_q;
    logic          pend_q, unf_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
        pend_q <= 1'b0;
        unf_q  <= 1'b0;
      end else if (clr) begin
        pend_q <= 1'b0;
        unf_q  <= 1'b0;
      end else begin
        if (push) begin
          dout_q <= din;
          pend_q <= 1'b1;
        end else if (pop) begin
          pend_q <= 1'b0;
        end
        if (pop && !pend_q) unf_q <= 1'b1;
      end
    end

    assign dout = dout_q;
    assign pend = pend_q;
    assign full = pend_q;
    assign ovf  = 1'b0;
    assign unf  = unf_q;
  end

endmodule

module jtframe_mailbox #(
  parameter int DW   = 8,
  parameter int AW   = 2,
  parameter int MODE = 1,
  parameter int EDGE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          host_wr,
  input  logic          host_rd,
  input  logic          host_clr,
  input  logic [DW-1:0] host_din,
  output logic [DW-1:0] host_dout,
  input  logic          sub_wr,
  input  logic          sub_rd,
  input  logic [DW-1:0] sub_din,
  output logic [DW-1:0] sub_dout,
  output logic          h2s_pend,
  output logic          s2h_pend,
  output logic          h2s_full,
  output logic          s2h_full,
  output logic [1:0]    ovf,
  output logic [1:0]    unf
);

  logic [4:0] stb, prev_q, ev;

  assign stb = {host_clr, sub_rd, sub_wr, host_rd, host_wr};

  // Edge history resets high so a strobe held across reset release is not taken as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   prev_q <= '1;
    else if (cen) prev_q <= stb;
  end

  assign ev = (EDGE != 0) ? (stb & ~prev_q & {5{cen}}) : (stb & {5{cen}});

  jtframe_mailbox_q #(.DW(DW), .AW(AW), .MODE(MODE)) u_h2s (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ev[4]),
    .push  (ev[0]),
    .pop   (ev[3]),
    .din   (host_din),
    .dout  (sub_dout),
    .pend  (h2s_pend),
    .full  (h2s_full),
    .ovf   (ovf[0]),
    .unf   (unf[0])
  );

  jtframe_mailbox_q #(.DW(DW), .AW(AW), .MODE(MODE)) u_s2h (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ev[4]),
    .push  (ev[2]),
    .pop   (ev[1]),
    .din   (sub_din),
    .dout  (host_dout),
    .pend  (s2h_pend),
    .full  (s2h_full),
    .ovf   (ovf[1]),
    .unf   (unf[1])
  );

endmodule

// File: tb/tb_jtframe_mailbox.sv
// Bench for jtframe_mailbox: FIFO/edge, latch/edge and FIFO/level instances on shared inputs.
// Directed table and corner sequences, then random traffic against a queue-based model.
module tb_jtframe_mailbox;

  typedef struct packed {
    logic [7:0] host_dout;
    logic [7:0] sub_dout;
    logic       h2s_pend;
    logic       s2h_pend;
    logic       h2s_full;
    logic       s2h_full;
    logic [1:0] ovf;
    logic [1:0] unf;
  } out_t;

  typedef struct {
    logic       hw, hr, hc, sw, sr;
    logic [7:0] hd, sd;
    out_t       exp;
  } vec_t;

  localparam int DEPTH = 4;
  localparam int FIFO  = 0;
  localparam int LATCH = 1;
  localparam int LVL   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cen, host_wr, host_rd, host_clr, sub_wr, sub_rd;
  logic [7:0] host_din, sub_din;

  logic [7:0] hd_o [3];
  logic [7:0] sd_o [3];
  logic       hp_o [3];
  logic       sp_o [3];
  logic       hf_o [3];
  logic       sf_o [3];
  logic [1:0] ovf_o [3];
  logic [1:0] unf_o [3];

  int n_cmp = 0;
  int n_bad = 0;

  jtframe_mailbox #(.DW(8), .AW(2), .MODE(1), .EDGE(1)) u_fifo (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .host_wr(host_wr), .host_rd(host_rd), .host_clr(host_clr),
    .host_din(host_din), .host_dout(hd_o[FIFO]),
    .sub_wr(sub_wr), .sub_rd(sub_rd), .sub_din(sub_din), .sub_dout(sd_o[FIFO]),
    .h2s_pend(hp_o[FIFO]), .s2h_pend(sp_o[FIFO]),
    .h2s_full(hf_o[FIFO]), .s2h_full(sf_o[FIFO]),
    .ovf(ovf_o[FIFO]), .unf(unf_o[FIFO])
  );

  jtframe_mailbox #(.DW(8), .AW(2), .MODE(0), .EDGE(1)) u_latch (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .host_wr(host_wr), .host_rd(host_rd), .host_clr(host_clr),
    .host_din(host_din), .host_dout(hd_o[LATCH]),
    .sub_wr(sub_wr), .sub_rd(sub_rd), .sub_din(sub_din), .sub_dout(sd_o[LATCH]),
    .h2s_pend(hp_o[LATCH]), .s2h_pend(sp_o[LATCH]),
    .h2s_full(hf_o[LATCH]), .s2h_full(sf_o[LATCH]),
    .ovf(ovf_o[LATCH]), .unf(unf_o[LATCH])
  );

  jtframe_mailbox #(.DW(8), .AW(2), .MODE(1), .EDGE(0)) u_lvl (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .host_wr(host_wr), .host_rd(host_rd), .host_clr(host_clr),
    .host_din(host_din), .host_dout(hd_o[LVL]),
    .sub_wr(sub_wr), .sub_rd(sub_rd), .sub_din(sub_din), .sub_dout(sd_o[LVL]),
    .h2s_pend(hp_o[LVL]), .s2h_pend(sp_o[LVL]),
    .h2s_full(hf_o[LVL]), .s2h_full(sf_o[LVL]),
    .ovf(ovf_o[LVL]), .unf(unf_o[LVL])
  );

  function automatic out_t get(input int k);
    get = '{hd_o[k], sd_o[k], hp_o[k], sp_o[k], hf_o[k], sf_o[k], ovf_o[k], unf_o[k]};
  endfunction

  function automatic out_t mk(input logic [7:0] h, s, input logic hp, sp, hf, sf,
                              input logic [1:0] ov, un);
    mk = '{h, s, hp, sp, hf, sf, ov, un};
  endfunction

  task automatic check(input string nm, input int k, input out_t exp);
    out_t act;
    act = get(k);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got hdo=%h sdo=%h hp=%b sp=%b hf=%b sf=%b ovf=%b unf=%b, want hdo=%h sdo=%h hp=%b sp=%b hf=%b sf=%b ovf=%b unf=%b",
               nm, act.host_dout, act.sub_dout, act.h2s_pend, act.s2h_pend, act.h2s_full,
               act.s2h_full, act.ovf, act.unf, exp.host_dout, exp.sub_dout, exp.h2s_pend,
               exp.s2h_pend, exp.h2s_full, exp.s2h_full, exp.ovf, exp.unf);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    host_wr = 1'b0; host_rd = 1'b0; host_clr = 1'b0; sub_wr = 1'b0; sub_rd = 1'b0;
  endtask

  task automatic pulse(input logic hw, hr, hc, sw, sr, input logic [7:0] hd, sd);
    host_wr = hw; host_rd = hr; host_clr = hc; sub_wr = sw; sub_rd = sr;
    host_din = hd; sub_din = sd;
    tick();
    idle();
    tick();
  endtask

  task automatic do_reset();
    idle();
    cen   = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Reference model: two bounded queues; a pop is applied before a push in the same cycle.
  logic [7:0] mq_h2s[$];
  logic [7:0] mq_s2h[$];
  logic [7:0] m_sdo, m_hdo;
  logic [1:0] m_ovf, m_unf;

  task automatic model_reset();
    mq_h2s.delete(); mq_s2h.delete();
    m_sdo = 8'h00; m_hdo = 8'h00; m_ovf = 2'b00; m_unf = 2'b00;
  endtask

  task automatic model_step(input logic hw, hr, hc, sw, sr, input logic [7:0] hd, sd);
    if (hc) begin
      mq_h2s.delete(); mq_s2h.delete();
      m_ovf = 2'b00; m_unf = 2'b00;
    end else begin
      if (sr) begin
        if (mq_h2s.size() == 0) m_unf[0] = 1'b1;
        else void'(mq_h2s.pop_front());
      end
      if (hw) begin
        if (mq_h2s.size() < DEPTH) mq_h2s.push_back(hd);
        else m_ovf[0] = 1'b1;
      end
      if (mq_h2s.size() != 0) m_sdo = mq_h2s[0];
      if (hr) begin
        if (mq_s2h.size() == 0) m_unf[1] = 1'b1;
        else void'(mq_s2h.pop_front());
      end
      if (sw) begin
        if (mq_s2h.size() < DEPTH) mq_s2h.push_back(sd);
        else m_ovf[1] = 1'b1;
      end
      if (mq_s2h.size() != 0) m_hdo = mq_s2h[0];
    end
  endtask

  function automatic out_t model_out();
    model_out = '{m_hdo, m_sdo, mq_h2s.size() != 0, mq_s2h.size() != 0,
                  mq_h2s.size() == DEPTH, mq_s2h.size() == DEPTH, m_ovf, m_unf};
  endfunction

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 8'h00, mk(8'h00, 8'h11, 1, 0, 0, 0, 2'b00, 2'b00)};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 8'h00, mk(8'h00, 8'h11, 1, 0, 0, 0, 2'b00, 2'b00)};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 8'h00, mk(8'h00, 8'h11, 1, 0, 0, 0, 2'b00, 2'b00)};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44, 8'h00, mk(8'h00, 8'h11, 1, 0, 1, 0, 2'b00, 2'b00)};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 8'h00, mk(8'h00, 8'h11, 1, 0, 1, 0, 2'b01, 2'b00)};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, mk(8'h00, 8'h22, 1, 0, 0, 0, 2'b01, 2'b00)};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, mk(8'h00, 8'h33, 1, 0, 0, 0, 2'b01, 2'b00)};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, mk(8'h00, 8'h44, 1, 0, 0, 0, 2'b01, 2'b00)};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, mk(8'h00, 8'h44, 0, 0, 0, 0, 2'b01, 2'b00)};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, mk(8'h00, 8'h44, 0, 0, 0, 0, 2'b01, 2'b01)};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hAA, mk(8'hAA, 8'h44, 0, 1, 0, 0, 2'b01, 2'b01)};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hBB, mk(8'hBB, 8'h44, 0, 1, 0, 0, 2'b01, 2'b01)};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, mk(8'hBB, 8'h44, 0, 0, 0, 0, 2'b01, 2'b01)};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, mk(8'hBB, 8'h44, 0, 0, 0, 0, 2'b01, 2'b11)};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, mk(8'hBB, 8'h44, 0, 0, 0, 0, 2'b00, 2'b00)};

    host_din = 8'h00; sub_din = 8'h00;
    idle();
    cen = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    check("reset_fifo",  FIFO,  '0);
    check("reset_latch", LATCH, '0);
    check("reset_level", LVL,   '0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      pulse(tbl[i].hw, tbl[i].hr, tbl[i].hc, tbl[i].sw, tbl[i].sr, tbl[i].hd, tbl[i].sd);
      check($sformatf("table_%0d", i), FIFO, tbl[i].exp);
    end

    // Push and pop together on a full queue: no overflow, order preserved.
    pulse(1, 0, 0, 0, 0, 8'hA1, 8'h00);
    pulse(1, 0, 0, 0, 0, 8'hB2, 8'h00);
    pulse(1, 0, 0, 0, 0, 8'hC3, 8'h00);
    pulse(1, 0, 0, 0, 0, 8'hD4, 8'h00);
    check("full_before", FIFO, mk(8'hBB, 8'hA1, 1, 0, 1, 0, 2'b00, 2'b00));
    pulse(1, 0, 0, 0, 1, 8'hE5, 8'h00);
    check("full_pushpop", FIFO, mk(8'hBB, 8'hB2, 1, 0, 1, 0, 2'b00, 2'b00));
    pulse(0, 0, 0, 0, 1, 8'h00, 8'h00);
    check("full_pop_c", FIFO, mk(8'hBB, 8'hC3, 1, 0, 0, 0, 2'b00, 2'b00));
    pulse(0, 0, 0, 0, 1, 8'h00, 8'h00);
    check("full_pop_d", FIFO, mk(8'hBB, 8'hD4, 1, 0, 0, 0, 2'b00, 2'b00));
    pulse(0, 0, 0, 0, 1, 8'h00, 8'h00);
    check("full_pop_e", FIFO, mk(8'hBB, 8'hE5, 1, 0, 0, 0, 2'b00, 2'b00));
    pulse(0, 0, 0, 0, 1, 8'h00, 8'h00);
    check("full_drained", FIFO, mk(8'hBB, 8'hE5, 0, 0, 0, 0, 2'b00, 2'b00));

    // Clear wins over a simultaneous push.
    pulse(1, 0, 0, 0, 0, 8'h01, 8'h00);
    pulse(1, 0, 0, 0, 0, 8'h02, 8'h00);
    pulse(1, 0, 1, 0, 0, 8'h77, 8'h00);
    check("clr_prio", FIFO, mk(8'hBB, 8'h01, 0, 0, 0, 0, 2'b00, 2'b00));
    pulse(1, 0, 0, 0, 0, 8'h99, 8'h00);
    check("clr_then_push", FIFO, mk(8'hBB, 8'h99, 1, 0, 0, 0, 2'b00, 2'b00));
    pulse(0, 0, 0, 0, 1, 8'h00, 8'h00);
    check("clr_then_pop", FIFO, mk(8'hBB, 8'h99, 0, 0, 0, 0, 2'b00, 2'b00));

    // Legacy latch mode.
    do_reset();
    pulse(1, 0, 0, 0, 0, 8'h5A, 8'h00);
    check("latch_w1", LATCH, mk(8'h00, 8'h5A, 1, 0, 1, 0, 2'b00, 2'b00));
    pulse(1, 0, 0, 0, 0, 8'hA5, 8'h00);
    check("latch_w2", LATCH, mk(8'h00, 8'hA5, 1, 0, 1, 0, 2'b00, 2'b00));
    pulse(0, 0, 0, 0, 1, 8'h00, 8'h00);
    check("latch_pop", LATCH, mk(8'h00, 8'hA5, 0, 0, 0, 0, 2'b00, 2'b00));
    pulse(0, 0, 0, 0, 1, 8'h00, 8'h00);
    check("latch_unf", LATCH, mk(8'h00, 8'hA5, 0, 0, 0, 0, 2'b00, 2'b01));
    pulse(1, 0, 0, 0, 1, 8'h3C, 8'h00);
    check("latch_pushpop", LATCH, mk(8'h00, 8'h3C, 1, 0, 1, 0, 2'b00, 2'b01));
    pulse(0, 0, 0, 1, 0, 8'h00, 8'hC3);
    check("latch_s2h", LATCH, mk(8'hC3, 8'h3C, 1, 1, 1, 1, 2'b00, 2'b01));
    pulse(0, 0, 1, 0, 0, 8'h00, 8'h00);
    check("latch_clr", LATCH, mk(8'hC3, 8'h3C, 0, 0, 0, 0, 2'b00, 2'b00));

    // Asynchronous reset mid-stream, with host_wr held high across release.
    pulse(1, 0, 0, 0, 0, 8'h01, 8'h00);
    pulse(1, 0, 0, 0, 0, 8'h02, 8'h00);
    pulse(1, 0, 0, 0, 0, 8'h03, 8'h00);
    host_wr = 1'b1; host_din = 8'hEE;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", FIFO, '0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("held_wr_release", FIFO, '0);
    host_wr = 1'b0;
    tick();
    check("held_wr_low", FIFO, '0);
    pulse(1, 0, 0, 0, 0, 8'h42, 8'h00);
    check("post_reset_push", FIFO, mk(8'h00, 8'h42, 1, 0, 0, 0, 2'b00, 2'b00));

    // A strobe held high for several cycles is a single event.
    host_wr = 1'b1; host_din = 8'h66;
    tick(); tick(); tick();
    host_wr = 1'b0;
    tick();
    check("held_wr_once", FIFO, mk(8'h00, 8'h42, 1, 0, 0, 0, 2'b00, 2'b00));
    pulse(0, 0, 0, 0, 1, 8'h00, 8'h00);
    check("held_pop1", FIFO, mk(8'h00, 8'h66, 1, 0, 0, 0, 2'b00, 2'b00));
    pulse(0, 0, 0, 0, 1, 8'h00, 8'h00);
    check("held_pop2", FIFO, mk(8'h00, 8'h66, 0, 0, 0, 0, 2'b00, 2'b00));

    // Random traffic on the level-sensitive FIFO against the queue model.
    do_reset();
    model_reset();
    for (int i = 0; i < 600; i++) begin
      cen      = ($urandom_range(3) != 0);
      host_wr  = ($urandom_range(9) < 4);
      host_rd  = ($urandom_range(9) < 4);
      sub_wr   = ($urandom_range(9) < 4);
      sub_rd   = ($urandom_range(9) < 4);
      host_clr = ($urandom_range(39) == 0);
      host_din = 8'($urandom);
      sub_din  = 8'($urandom);
      tick();
      if (cen) model_step(host_wr, host_rd, host_clr, sub_wr, sub_rd, host_din, sub_din);
      check($sformatf("random_%0d", i), LVL, model_out());
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
